pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS datapath, and the successor to the plain PC register. It holds the PC and selects the next-PC source: sequential, branch, jump, register jump or exception vector. It also supports stall and flags misaligned register targets. A small circular return-address stack (RAS) records `jal`/`jalr` links and checks `jr $ra` targets, giving later fetch-prediction work its hook.

---
 rtl/pc_unit.sv | 143 ++++++++++++++
 tb/tb_pc_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, picks the next fetch address
// (sequential, branch, jump, register jump, exception vector), and keeps a
// small circular return-address stack that checks `jr $ra` targets.
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] EXC_VECTOR   = 64'h0000_0180,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           exception,
    input  logic                           branch_taken,
    input  logic [15:0]                    branch_imm,
    input  logic                           jump,
    input  logic [25:0]                    jump_index,
    input  logic                           jump_reg,
    input  logic [WIDTH-1:0]               reg_target,
    input  logic                           link,
    input  logic                           ret,
    output logic [WIDTH-1:0]               pc,
    output logic [WIDTH-1:0]               pc_plus4,
    output logic [WIDTH-1:0]               ras_top,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_mispredict,
    output logic                           addr_error
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] RESET_PC = RESET_VECTOR[WIDTH-1:0];
    localparam logic [WIDTH-1:0] EXC_PC   = EXC_VECTOR[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_count_q, ras_count_d;
    logic             mispredict_q, mispredict_d;
    logic             addr_error_q, addr_error_d;
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             reg_misaligned;
    logic             redirect_ok;
    logic             ras_push;
    logic             ras_pop;
    logic [PTR_W-1:0] push_ptr;

    assign pc_plus4      = pc_q + WIDTH'(4);
    assign branch_target = pc_plus4 + {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};

    // A 28-bit PC has no region bits above the jump index to carry over.
    generate
        if (WIDTH > 28) begin : g_jump_region
            assign jump_target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {jump_index, 2'b00};
        end
    endgenerate

    assign reg_misaligned = jump_reg && (reg_target[1:0] != 2'b00);
    // RAS only moves on a cycle whose control transfer actually commits.
    assign redirect_ok    = !reset && !stall && !exception && !reg_misaligned;
    assign ras_push       = redirect_ok && (jump || jump_reg) && link;
    assign ras_pop        = redirect_ok && jump_reg && ret && !link;
    assign push_ptr       = ras_ptr_q + PTR_W'(1);

    assign ras_top        = (ras_count_q == '0) ? '0 : ras_mem_q[ras_ptr_q];
    assign ras_count      = ras_count_q;
    assign ras_empty      = (ras_count_q == '0);
    assign pc             = pc_q;
    assign ras_mispredict = mispredict_q;
    assign addr_error     = addr_error_q;

    // Next-PC selection and RAS pointer/count/pulse update.
    always_comb begin
        pc_d         = pc_plus4;
        ras_ptr_d    = ras_ptr_q;
        ras_count_d  = ras_count_q;
        mispredict_d = 1'b0;
        addr_error_d = 1'b0;

        // Stall outranks every transfer except an exception.
        if (exception) begin
            pc_d = EXC_PC;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (reg_misaligned) begin
            pc_d         = EXC_PC;
            addr_error_d = 1'b1;
        end else if (jump_reg) begin
            pc_d = reg_target;
        end else if (jump) begin
            pc_d = jump_target;
        end else if (branch_taken) begin
            pc_d = branch_target;
        end

        if (ras_push) begin
            // When full the pointer wraps onto the oldest entry.
            ras_ptr_d = push_ptr;
            if (ras_count_q != CNT_FULL) begin
                ras_count_d = ras_count_q + CNT_W'(1);
            end
        end else if (ras_pop) begin
            if (ras_count_q == '0) begin
                mispredict_d = 1'b1;
            end else begin
                ras_ptr_d    = ras_ptr_q - PTR_W'(1);
                ras_count_d  = ras_count_q - CNT_W'(1);
                mispredict_d = (reg_target != ras_top);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ras_ptr_q    <= '0;
            ras_count_q  <= '0;
            mispredict_q <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ras_ptr_q    <= ras_ptr_d;
            ras_count_q  <= ras_count_d;
            mispredict_q <= mispredict_d;
            addr_error_q <= addr_error_d;
        end
    end

    // RAS storage write; contents need no reset since ras_count gates reads.
    always_ff @(posedge clock) begin
        if (ras_push) begin
            ras_mem_q[push_ptr] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expected values.
module tb_pc_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             stall;
    logic             exception;
    logic             branch_taken;
    logic [15:0]      branch_imm;
    logic             jump;
    logic [25:0]      jump_index;
    logic             jump_reg;
    logic [WIDTH-1:0] reg_target;
    logic             link;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] ras_top;
    logic [2:0]       ras_count;
    logic             ras_empty;
    logic             ras_mispredict;
    logic             addr_error;

    int n_tests = 0;
    int n_fail  = 0;

    pc_unit #(
        .WIDTH(WIDTH),
        .RESET_VECTOR(64'h0),
        .EXC_VECTOR(64'h180),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .exception(exception),
        .branch_taken(branch_taken),
        .branch_imm(branch_imm),
        .jump(jump),
        .jump_index(jump_index),
        .jump_reg(jump_reg),
        .reg_target(reg_target),
        .link(link),
        .ret(ret),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .ras_top(ras_top),
        .ras_count(ras_count),
        .ras_empty(ras_empty),
        .ras_mispredict(ras_mispredict),
        .addr_error(addr_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        stall        = 1'b0;
        exception    = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_index   = 26'h0;
        jump_reg     = 1'b0;
        reg_target   = '0;
        link         = 1'b0;
        ret          = 1'b0;
    endtask

    // Advance one edge, then clear controls so outputs are sampled #1 after it.
    task automatic step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic jr_to(input logic [31:0] tgt, input logic lnk, input logic rt);
        jump_reg   = 1'b1;
        reg_target = tgt;
        link       = lnk;
        ret        = rt;
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset_pc", pc, 32'h0);
        check("reset_ras_empty", ras_empty, 1'b1);
        check("reset_ras_count", ras_count, 3'd0);
        check("reset_ras_top", ras_top, 32'h0);
        check("reset_mispredict", ras_mispredict, 1'b0);
        check("reset_addr_error", addr_error, 1'b0);

        step(); check("seq_pc4", pc, 32'h4);
        step(); check("seq_pc8", pc, 32'h8);
        step(); check("seq_pc12", pc, 32'hC);
        check("seq_ras_empty", ras_empty, 1'b1);

        // Reset beats exception and stall.
        reset = 1'b1; exception = 1'b1; stall = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_pc", pc, 32'h0);

        jr_to(32'h100, 1'b0, 1'b0);
        check("jr_to_100", pc, 32'h100);
        branch_taken = 1'b1; branch_imm = 16'hFFFE;
        step();
        check("branch_back", pc, 32'hFC);
        check("pc_plus4", pc_plus4, 32'h100);

        jr_to(32'h1000_0000, 1'b0, 1'b0);
        jump = 1'b1; jump_index = 26'h40;
        step();
        check("jump_region", pc, 32'h1000_0100);

        stall = 1'b1; branch_taken = 1'b1; branch_imm = 16'h0010;
        step();
        check("stall_branch", pc, 32'h1000_0100);

        stall = 1'b1; exception = 1'b1;
        step();
        check("stall_exception", pc, 32'h180);

        jump = 1'b1; jump_index = 26'h5; jump_reg = 1'b1; reg_target = 32'h2000;
        step();
        check("jr_over_j", pc, 32'h2000);

        // Misaligned jalr: exception vector, one-cycle pulse, no push.
        jr_to(32'h2002, 1'b1, 1'b0);
        check("misalign_pc", pc, 32'h180);
        check("misalign_pulse", addr_error, 1'b1);
        check("misalign_no_push", ras_count, 3'd0);
        step();
        check("misalign_pulse_end", addr_error, 1'b0);
        check("misalign_next_pc", pc, 32'h184);

        // Stalled jal must not push.
        stall = 1'b1; jump = 1'b1; link = 1'b1; jump_index = 26'h10;
        step();
        check("stall_no_push", ras_count, 3'd0);

        // Call/return matched.
        jr_to(32'h40, 1'b0, 1'b0);
        jump = 1'b1; link = 1'b1; jump_index = 26'h10;
        step();
        check("jal_pc", pc, 32'h40);
        check("jal_ras_top", ras_top, 32'h44);
        check("jal_ras_count", ras_count, 3'd1);
        jr_to(32'h44, 1'b0, 1'b1);
        check("ret_ok_empty", ras_empty, 1'b1);
        check("ret_ok_no_mis", ras_mispredict, 1'b0);
        check("ret_ok_pc", pc, 32'h44);

        // Call/return mismatched.
        jr_to(32'h40, 1'b0, 1'b0);
        jump = 1'b1; link = 1'b1; jump_index = 26'h10;
        step();
        check("jal2_ras_top", ras_top, 32'h44);
        jr_to(32'h48, 1'b0, 1'b1);
        check("ret_bad_mis", ras_mispredict, 1'b1);
        check("ret_bad_popped", ras_empty, 1'b1);
        step();
        check("ret_bad_pulse_end", ras_mispredict, 1'b0);

        // Return with empty stack.
        jr_to(32'h44, 1'b0, 1'b1);
        check("ret_empty_mis", ras_mispredict, 1'b1);
        check("ret_empty_count", ras_count, 3'd0);

        // Overflow: five jalr pushes with links 0x1004..0x5004.
        jr_to(32'h1000, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            jr_to(32'h1000 * (k + 1), 1'b1, 1'b0);
        end
        check("ovf_count", ras_count, 3'd4);
        check("ovf_top", ras_top, 32'h5004);
        for (int j = 5; j >= 2; j--) begin
            check($sformatf("ovf_pop_top_%0d", j), ras_top, 32'h1000 * j + 4);
            jr_to(32'h1000 * j + 4, 1'b0, 1'b1);
            check($sformatf("ovf_pop_mis_%0d", j), ras_mispredict, 1'b0);
        end
        check("ovf_drained", ras_empty, 1'b1);
        jr_to(32'h100, 1'b0, 1'b1);
        check("ovf_fifth_mis", ras_mispredict, 1'b1);
        check("ovf_fifth_count", ras_count, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
